// File: rtl/data_sram_responder_pkg.sv
// Shared types and defaults for the data-side SRAM-like responder.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int          DEF_DEPTH_LOG2  = 12;
  localparam int          DEF_LATENCY     = 1;
  localparam int          DEF_OUTSTANDING = 2;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

  // x^16+x^14+x^13+x^11 in right-shift form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } q_entry_t;

endpackage

// File: rtl/data_sram_resp_queue.sv
// In-order response FIFO; each entry counts down its remaining latency.
module data_sram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  q_entry_t      push_entry,
  output q_entry_t      head,
  output logic          head_ready,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  q_entry_t         ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wptr, rptr;
  logic             pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head       = ent[rptr];
  assign head_ready = vld[rptr] & (head.cnt == 4'd0);
  assign pop        = head_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic     set, clr, v;
    q_entry_t e;

    assign set    = push & (wptr == PW'(i));
    assign clr    = pop & (rptr == PW'(i));
    assign vld[i] = v;
    assign ent[i] = e;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  v <= 1'b0;
      else if (set) v <= 1'b1;
      else if (clr) v <= 1'b0;
    end

    // payload is never reset; stale counters on free slots are harmless
    always_ff @(posedge clk) begin
      if (set)                  e     <= push_entry;
      else if (e.cnt != 4'd0)   e.cnt <= e.cnt - 4'd1;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: word memory, fixed latency, bounded
// outstanding requests, in-order responses, optional LFSR backpressure.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int          LATENCY     = DEF_LATENCY,
  parameter int          OUTSTANDING = DEF_OUTSTANDING,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int            CW      = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(OUTSTANDING);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hs, stall_ok, head_ready;
  logic [CW-1:0]         count;
  q_entry_t              push_entry, head;
  logic                  unused_ok;

  assign idx     = addr[DEPTH_LOG2+1:2];
  assign addr_ok = (count < MAX_OUT) & stall_ok;
  assign hs      = req & addr_ok;

  always_ff @(posedge clk) begin
    if (hs && wr)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  // load data is read before this edge's store; only one request per cycle
  assign push_entry = '{is_wr: wr, data: wr ? 32'd0 : mem[idx], cnt: 4'(LATENCY - 1)};

  if (RAND_STALL) begin : g_lfsr
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr <= LFSR_SEED;
      else         lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
    assign stall_ok = lfsr[0];
  end else begin : g_no_lfsr
    assign stall_ok = 1'b1;
  end

  data_sram_resp_queue #(.DEPTH(OUTSTANDING), .CW(CW)) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (hs),
    .push_entry (push_entry),
    .head       (head),
    .head_ready (head_ready),
    .count      (count)
  );

  assign data_ok = head_ready;
  assign rdata   = head_ready ? head.data : 32'd0;

  assign unused_ok = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0], head.is_wr, head.cnt};

endmodule

// File: tb/tb_data_sram_responder.sv
// Three responder configurations checked every cycle against a
// transaction-level model, plus hand-computed directed checks.
module tb_data_sram_responder;

  localparam int LAT  [3] = '{1, 3, 2};
  localparam int OUTS [3] = '{2, 2, 3};
  localparam int RS   [3] = '{0, 0, 1};
  localparam int DL   [3] = '{12, 12, 4};

  logic        clk = 1'b0;
  logic        resetn;
  logic        req   [3];
  logic        wr    [3];
  logic [1:0]  size  [3];
  logic [3:0]  wstrb [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic [31:0] rdata   [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.DEPTH_LOG2(DL[0]), .LATENCY(LAT[0]), .OUTSTANDING(OUTS[0]),
                        .RAND_STALL(RS[0] != 0), .LFSR_SEED(16'hACE1)) u_dut0 (
    .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]), .wstrb(wstrb[0]),
    .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));

  data_sram_responder #(.DEPTH_LOG2(DL[1]), .LATENCY(LAT[1]), .OUTSTANDING(OUTS[1]),
                        .RAND_STALL(RS[1] != 0), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]), .wstrb(wstrb[1]),
    .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));

  data_sram_responder #(.DEPTH_LOG2(DL[2]), .LATENCY(LAT[2]), .OUTSTANDING(OUTS[2]),
                        .RAND_STALL(RS[2] != 0), .LFSR_SEED(16'hACE1)) u_dut2 (
    .clk(clk), .resetn(resetn), .req(req[2]), .wr(wr[2]), .size(size[2]), .wstrb(wstrb[2]),
    .addr(addr[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- model: memory image + expected response list ----------------
  logic [31:0] mm        [3][4096];
  bit          mk        [3][4096];
  logic [31:0] e_data    [3][8];
  bit          e_known   [3][8];
  int          e_due     [3][8];
  int          e_h       [3] = '{0, 0, 0};
  int          e_n       [3] = '{0, 0, 0};
  int          last_resp [3] = '{-100, -100, -100};
  logic [15:0] lf        [3] = '{16'hACE1, 16'hACE1, 16'hACE1};
  int          resp_cnt  [3] = '{0, 0, 0};

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      bit x_ok, x_dv;
      int idx, t;
      if (!resetn) begin
        e_n[d] = 0; e_h[d] = 0; last_resp[d] = -100; lf[d] = 16'hACE1;
      end
      x_ok = (e_n[d] < OUTS[d]) && (RS[d] == 0 || lf[d][0]);
      x_dv = (e_n[d] > 0) && (e_due[d][e_h[d]] == cyc);
      chk("addr_ok", d, 32'(addr_ok[d]), 32'(x_ok));
      chk("data_ok", d, 32'(data_ok[d]), 32'(x_dv));
      if (x_dv && e_known[d][e_h[d]]) chk("rdata", d, rdata[d], e_data[d][e_h[d]]);
      else if (!x_dv)                 chk("rdata_idle", d, rdata[d], 32'h0);
      if (data_ok[d] === 1'b1) resp_cnt[d]++;
      if (x_dv) begin
        e_h[d] = (e_h[d] + 1) % 8;
        e_n[d]--;
      end
      if (resetn && req[d] && x_ok) begin
        idx = int'((addr[d] >> 2) & ((32'd1 << DL[d]) - 32'd1));
        t   = (e_h[d] + e_n[d]) % 8;
        e_due[d][t]  = (cyc + LAT[d] > last_resp[d] + 1) ? cyc + LAT[d] : last_resp[d] + 1;
        last_resp[d] = e_due[d][t];
        if (wr[d]) begin
          e_data[d][t]  = 32'h0;
          e_known[d][t] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (wstrb[d][b]) mm[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
          if (wstrb[d] == 4'hF) mk[d][idx] = 1'b1;
        end else begin
          e_data[d][t]  = mm[d][idx];
          e_known[d][t] = mk[d][idx];
        end
        e_n[d]++;
      end
      if (resetn) lf[d] = lfsr_next(lf[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic [1:0] sz, output int h);
    int n = 0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = wd; size[d] = sz;
    @(negedge clk);
    while (addr_ok[d] !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("issue_timeout", d, 32'(addr_ok[d]), 32'd1);
    h = cyc;
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input logic [31:0] e, input string nm);
    int n = 0;
    @(negedge clk);
    while (data_ok[d] !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_ok"}, d, 32'(data_ok[d]), 32'd1);
    chk(nm, d, rdata[d], e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, h3, hf;
    resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd2; wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    @(negedge clk);
    chk("rst_data_ok", 0, 32'(data_ok[0]), 32'd0);
    chk("rst_rdata", 0, rdata[0], 32'h0);
    chk("rst_addr_ok", 0, 32'(addr_ok[0]), 32'd1);
    chk("rst_addr_ok_seed", 2, 32'(addr_ok[2]), 32'd1);
    idle(2);
    resetn = 1'b1;
    // seed 0xACE1 -> 0x5670: addr_ok pattern 1 then 0
    @(negedge clk);
    chk("lfsr_bit0", 2, 32'(addr_ok[2]), 32'd1);
    @(negedge clk);
    chk("lfsr_bit1", 2, 32'(addr_ok[2]), 32'd0);
    idle(1);

    // store then load, LATENCY 1: responses on consecutive cycles
    issue(0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 2'd2, h);
    chk("st_ack_ok", 0, 32'(data_ok[0]), 32'd1);
    chk("st_ack_data", 0, rdata[0], 32'h0);
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, 2'd2, h);
    chk("ld_ok", 0, 32'(data_ok[0]), 32'd1);
    chk("ld_data", 0, rdata[0], 32'hDEADBEEF);

    // byte-lane store, unaligned byte load returns full word
    issue(0, 1'b1, 32'h1000, 4'b0100, 32'h00AA0000, 2'd0, h);
    issue(0, 1'b0, 32'h1003, 4'h0, 32'h0, 2'd0, h);
    chk("lane_data", 0, rdata[0], 32'hDEAABEEF);
    idle(3);

    // LATENCY 3, OUTSTANDING 2: third load waits until a slot frees
    issue(1, 1'b1, 32'h10, 4'hF, 32'h11111111, 2'd2, h);
    issue(1, 1'b1, 32'h14, 4'hF, 32'h22222222, 2'd2, h);
    issue(1, 1'b1, 32'h18, 4'hF, 32'h33333333, 2'd2, h);
    idle(10);
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, 2'd2, h1);
    issue(1, 1'b0, 32'h14, 4'h0, 32'h0, 2'd2, h2);
    issue(1, 1'b0, 32'h18, 4'h0, 32'h0, 2'd2, h3);
    chk("hs_gap2", 1, 32'(h2 - h1), 32'd1);
    chk("hs_gap3", 1, 32'(h3 - h1), 32'd4);
    idle(10);
    chk("resp_count1", 1, 32'(resp_cnt[1]), 32'd6);

    // 20 back-to-back stores then loads: one handshake per cycle, pointers wrap
    for (int i = 0; i < 20; i++)
      issue(0, 1'b1, 32'h200 + 32'(4*i), 4'hF, 32'hA5000000 + 32'(i * 32'h01010101), 2'd2, h);
    for (int i = 0; i < 20; i++) begin
      issue(0, 1'b0, 32'h200 + 32'(4*i), 4'h0, 32'h0, 2'd2, h);
      if (i == 0) hf = h;
    end
    chk("b2b_span", 0, 32'(h - hf), 32'd19);
    idle(5);
    chk("resp_count0", 0, 32'(resp_cnt[0]), 32'd44);

    // DEPTH_LOG2 4: address 0x44 aliases word 1
    issue(2, 1'b1, 32'h04, 4'hF, 32'h12345678, 2'd2, h);
    wait_resp(2, 32'h0, "wrap_st");
    issue(2, 1'b0, 32'h44, 4'h0, 32'h0, 2'd2, h);
    wait_resp(2, 32'h12345678, "wrap_ld");

    // random traffic under LFSR backpressure
    for (int i = 0; i < 16; i++)
      issue(2, 1'b1, 32'(4*i), 4'hF, $urandom, 2'd2, h);
    for (int k = 0; k < 200; k++) begin
      issue(2, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, 2)), h);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(12);

    // reset with two loads outstanding drops both; memory survives
    issue(1, 1'b0, 32'h14, 4'h0, 32'h0, 2'd2, h1);
    issue(1, 1'b0, 32'h18, 4'h0, 32'h0, 2'd2, h2);
    idle(1);
    chk("pre_rst_ok", 1, 32'(data_ok[1]), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_data_ok", 1, 32'(data_ok[1]), 32'd0);
    chk("mid_rst_addr_ok", 1, 32'(addr_ok[1]), 32'd1);
    chk("mid_rst_rdata", 1, rdata[1], 32'h0);
    idle(2);
    resetn = 1'b1;
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, 2'd2, h);
    wait_resp(1, 32'h11111111, "post_rst_ld");
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
